// File: rtl/reg_bank_wr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_wr_pkg
//  Purpose  : Enable-bit indices, read-select codes and widths for reg_bank_wr
//  Revision : 1.0
// ============================================================================
package reg_bank_wr_pkg;

    localparam int c_data_w   = 16;
    localparam int c_num_regs = 20;

    // Bit positions within the decoder write-enable vector
    localparam int c_en_r1   = 0;
    localparam int c_en_r14  = 13;
    localparam int c_en_pc   = 14;
    localparam int c_en_totr = 15;
    localparam int c_en_mddr = 16;
    localparam int c_en_tr   = 17;
    localparam int c_en_ar   = 18;
    localparam int c_en_ir   = 19;

    localparam logic [c_num_regs-1:0] c_wr_bcast = 20'hFFFFF;

    // Read-select codes; codes 1..18 map to enable bit (code - 1)
    localparam logic [4:0] c_rd_r1   = 5'd1;
    localparam logic [4:0] c_rd_r14  = 5'd14;
    localparam logic [4:0] c_rd_pc   = 5'd15;
    localparam logic [4:0] c_rd_totr = 5'd16;
    localparam logic [4:0] c_rd_mddr = 5'd17;
    localparam logic [4:0] c_rd_tr   = 5'd18;
    localparam logic [4:0] c_rd_ar   = 5'd21;
    localparam logic [4:0] c_rd_ir   = 5'd22;

endpackage : reg_bank_wr_pkg
`default_nettype wire

// File: rtl/reg_bank_cell.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_cell
//  Purpose  : One bank register with sync reset, write, and optional increment
//  Revision : 1.0
// ============================================================================
module reg_bank_cell #(
    parameter int DATA_W  = 16,
    parameter bit HAS_INC = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic              i_inc_en,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // A write in the same cycle as an increment stores the bus value as-is
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_wr_en) begin
            r_q <= i_d;
        end else if (HAS_INC && i_inc_en) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;

endmodule : reg_bank_cell
`default_nettype wire

// File: rtl/reg_bank_wr.sv
`default_nettype none
// ============================================================================
//  Module   : reg_bank_wr
//  Purpose  : Register bank written from the one-hot decoder enable vector
//  Revision : 1.0
// ============================================================================
module reg_bank_wr
    import reg_bank_wr_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int TR_W   = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [c_num_regs-1:0] WRDec_out,
    input  logic [DATA_W-1:0]     bus_in,
    input  logic [4:0]            rd_sel,
    input  logic                  inc_pc,
    input  logic                  inc_ar,
    output logic [DATA_W-1:0]     bus_out,
    output logic [DATA_W-1:0]     PC_out,
    output logic [DATA_W-1:0]     AR_out,
    output logic [DATA_W-1:0]     IR_out,
    output logic [TR_W-1:0]       TR_out,
    output logic                  wr_err
);

    logic [DATA_W-1:0]     w_q [c_num_regs];
    logic [c_num_regs-1:0] w_wr_en;
    logic [c_num_regs-1:0] w_inc_en;
    logic                  w_zero;
    logic                  w_onehot;
    logic                  w_bcast;
    logic                  w_legal;
    logic                  r_wr_err;
    logic [DATA_W-1:0]     w_bus_out;

    // Clearing the lowest set bit leaves zero only for single-bit patterns
    assign w_zero   = (WRDec_out == '0);
    assign w_onehot = !w_zero &&
                      ((WRDec_out & (WRDec_out - {{(c_num_regs-1){1'b0}}, 1'b1})) == '0);
    assign w_bcast  = (WRDec_out == c_wr_bcast);
    assign w_legal  = w_zero || w_onehot || w_bcast;
    assign w_wr_en  = w_legal ? WRDec_out : '0;

    always_comb begin
        w_inc_en          = '0;
        w_inc_en[c_en_pc] = inc_pc;
        w_inc_en[c_en_ar] = inc_ar;
    end

    for (genvar i = 0; i < c_num_regs; i++) begin : g_cells
        reg_bank_cell #(
            .DATA_W  (DATA_W),
            .HAS_INC ((i == c_en_pc) || (i == c_en_ar))
        ) u_cell (
            .clk      (Clock),
            .rst      (Reset),
            .i_wr_en  (w_wr_en[i]),
            .i_inc_en (w_inc_en[i]),
            .i_d      (bus_in),
            .o_q      (w_q[i])
        );
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_err <= 1'b0;
        end else if (!w_legal) begin
            r_wr_err <= 1'b1;
        end
    end

    always_comb begin
        w_bus_out = '0;
        case (rd_sel)
            c_rd_ar: w_bus_out = w_q[c_en_ar];
            c_rd_ir: w_bus_out = w_q[c_en_ir];
            default: begin
                if (rd_sel >= c_rd_r1 && rd_sel <= c_rd_tr) begin
                    w_bus_out = w_q[rd_sel - 5'd1];
                end
            end
        endcase
    end

    assign bus_out = w_bus_out;
    assign PC_out  = w_q[c_en_pc];
    assign AR_out  = w_q[c_en_ar];
    assign IR_out  = w_q[c_en_ir];
    assign TR_out  = w_q[c_en_tr][TR_W-1:0];
    assign wr_err  = r_wr_err;

endmodule : reg_bank_wr
`default_nettype wire
